// File: rtl/multicycle_control.sv
// Multi-cycle RV64 sequencer: Moore FSM that drives the shared ALU / unified memory
// datapath, stalls on mem_ready, halts on illegal opcodes and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSource,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_HALT      = 4'd9
    } state_t;

    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    state_t cur, nxt;
    logic   retire;

    always_comb begin
        nxt = S_HALT;
        case (cur)
            S_FETCH:     nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LD, OP_SD:       nxt = S_MEM_ADDR;
                    OP_RTYPE, OP_ITYPE: nxt = S_EXECUTE;
                    OP_BEQ:             nxt = S_BRANCH;
                    default:            nxt = S_HALT;
                endcase
            end
            // The IR holds opcode, so only ld/sd can reach here; anything else is treated as illegal.
            S_MEM_ADDR: begin
                if (opcode == OP_LD)      nxt = S_MEM_READ;
                else if (opcode == OP_SD) nxt = S_MEM_WRITE;
                else                      nxt = S_HALT;
            end
            S_MEM_READ:  nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    nxt = S_FETCH;
            S_MEM_WRITE: nxt = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   nxt = S_ALU_WB;
            S_ALU_WB:    nxt = S_FETCH;
            S_BRANCH:    nxt = S_FETCH;
            default:     nxt = S_HALT;
        endcase
    end

    // Only completing states ever lead back into FETCH, and FETCH->FETCH is a stall.
    assign retire = (nxt == S_FETCH) && (cur != S_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= S_FETCH;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_ADD;
        case (cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                ALUSrcB = (opcode == OP_ITYPE) ? SRCB_IMM : SRCB_REG;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: ;
        endcase
        // A reset cycle must not commit architectural state, even from a stalled memory state.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
        end
    end

    assign state  = cur;
    assign halted = (cur == S_HALT);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/control/counter
// records are queued with the stimulus and compared as the DUT steps through them.
module tb_multicycle_control;

    localparam int CW = 4;
    localparam int OW = 19 + CW;

    localparam logic [6:0] LD = 7'b0000011, SD = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011;

    logic          clk, rst, mem_ready;
    logic [6:0]    opcode;
    logic          PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, RegWrite, ALUSrcA, halted;
    logic [1:0]    ALUSrcB, ALUOp;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .state(state), .halted(halted), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]    op;
        logic          rdy;
        logic [OW-1:0] v;
    } rec_t;

    rec_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] ret_model = '0;

    // Control bits: PCWrite PCWriteCond PCSource IorD MemRead MemWrite IRWrite MemtoReg RegWrite ALUSrcA ALUSrcB ALUOp
    function automatic logic [13:0] exp_ctl(input logic [3:0] st, input logic [6:0] op, input logic rdy);
        case (st)
            4'd0: return {rdy, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
            4'd1: return 14'b0_0_0_0_0_0_0_0_0_0_11_00;
            4'd2: return 14'b0_0_0_0_0_0_0_0_0_1_10_00;
            4'd3: return 14'b0_0_0_1_1_0_0_0_0_0_00_00;
            4'd4: return 14'b0_0_0_0_0_0_0_1_1_0_00_00;
            4'd5: return 14'b0_0_0_1_0_1_0_0_0_0_00_00;
            4'd6: return (op == IT) ? 14'b0_0_0_0_0_0_0_0_0_1_10_10 : 14'b0_0_0_0_0_0_0_0_0_1_00_10;
            4'd7: return 14'b0_0_0_0_0_0_0_0_1_0_00_00;
            4'd8: return 14'b0_1_1_0_0_0_0_0_0_1_00_01;
            default: return 14'b0;
        endcase
    endfunction

    function automatic logic [OW-1:0] obs();
        return {state, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, halted, retired};
    endfunction

    task automatic exp_cyc(input logic [6:0] op, input logic [3:0] st, input logic rdy);
        rec_t r;
        r.op  = op;
        r.rdy = rdy;
        r.v   = {st, exp_ctl(st, op, rdy), (st == 4'd9), ret_model};
        sb.push_back(r);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b0; opcode = 7'd0;
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd0 || retired !== '0) begin
            failures++; $display("FAIL reset_state got state=%0d retired=%0d want 0/0", state, retired);
        end
        mem_ready = 1'b1; #1;
        checks++;
        if ({PCWrite, RegWrite, MemWrite} !== 3'b000) begin
            failures++; $display("FAIL reset_strobes got %b want 000", {PCWrite, RegWrite, MemWrite});
        end
        mem_ready = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (state !== 4'd0 || halted !== 1'b0) begin
            failures++; $display("FAIL reset_release got state=%0d halted=%b want 0/0", state, halted);
        end
        ret_model = '0;
    endtask

    task automatic test_rtype();
        rec_t r;
        int c = 0;
        exp_cyc(RT, 0, 1); exp_cyc(RT, 1, 1); exp_cyc(RT, 6, 1); exp_cyc(RT, 7, 1);
        ret_model++;
        exp_cyc(RT, 0, 0);
        exp_cyc(IT, 0, 1); exp_cyc(IT, 1, 1); exp_cyc(IT, 6, 1); exp_cyc(IT, 7, 1);
        ret_model++;
        exp_cyc(IT, 0, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk); opcode = r.op; mem_ready = r.rdy; #1;
            checks++;
            if (obs() !== r.v) begin
                failures++; $display("FAIL alu_instr cyc%0d got=%h want=%h", c, obs(), r.v);
            end
            c++;
        end
    endtask

    task automatic test_load();
        rec_t r;
        int c = 0;
        exp_cyc(LD, 0, 1); exp_cyc(LD, 1, 1); exp_cyc(LD, 2, 1); exp_cyc(LD, 3, 1); exp_cyc(LD, 4, 1);
        ret_model++;
        exp_cyc(LD, 0, 1); exp_cyc(LD, 1, 1); exp_cyc(LD, 2, 1);
        exp_cyc(LD, 3, 0); exp_cyc(LD, 3, 0); exp_cyc(LD, 3, 1); exp_cyc(LD, 4, 0);
        ret_model++;
        exp_cyc(LD, 0, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk); opcode = r.op; mem_ready = r.rdy; #1;
            checks++;
            if (obs() !== r.v) begin
                failures++; $display("FAIL load cyc%0d got=%h want=%h", c, obs(), r.v);
            end
            c++;
        end
    endtask

    task automatic test_store_stall();
        rec_t r;
        int c = 0;
        int mw = 0;
        exp_cyc(SD, 0, 1); exp_cyc(SD, 1, 1); exp_cyc(SD, 2, 1);
        exp_cyc(SD, 5, 0); exp_cyc(SD, 5, 0); exp_cyc(SD, 5, 0); exp_cyc(SD, 5, 1);
        ret_model++;
        exp_cyc(SD, 0, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk); opcode = r.op; mem_ready = r.rdy; #1;
            if (MemWrite === 1'b1) mw++;
            checks++;
            if (obs() !== r.v) begin
                failures++; $display("FAIL store cyc%0d got=%h want=%h", c, obs(), r.v);
            end
            c++;
        end
        checks++;
        if (mw != 4) begin
            failures++; $display("FAIL store_memwrite_cycles got=%0d want=4", mw);
        end
    endtask

    task automatic test_branch();
        rec_t r;
        int c = 0;
        exp_cyc(BQ, 0, 1); exp_cyc(BQ, 1, 1); exp_cyc(BQ, 8, 1);
        ret_model++;
        exp_cyc(BQ, 0, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk); opcode = r.op; mem_ready = r.rdy; #1;
            checks++;
            if (obs() !== r.v) begin
                failures++; $display("FAIL branch cyc%0d got=%h want=%h", c, obs(), r.v);
            end
            c++;
        end
    endtask

    task automatic test_fetch_stall();
        rec_t r;
        int c = 0;
        repeat (5) exp_cyc(RT, 0, 0);
        exp_cyc(RT, 0, 1); exp_cyc(RT, 1, 1); exp_cyc(RT, 6, 1); exp_cyc(RT, 7, 1);
        ret_model++;
        exp_cyc(RT, 0, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk); opcode = r.op; mem_ready = r.rdy; #1;
            checks++;
            if (obs() !== r.v) begin
                failures++; $display("FAIL fetch_stall cyc%0d got=%h want=%h", c, obs(), r.v);
            end
            c++;
        end
    endtask

    task automatic test_back_to_back();
        rec_t r;
        int c = 0;
        exp_cyc(RT, 0, 1); exp_cyc(RT, 1, 1); exp_cyc(RT, 6, 1); exp_cyc(RT, 7, 1); ret_model++;
        exp_cyc(BQ, 0, 1); exp_cyc(BQ, 1, 1); exp_cyc(BQ, 8, 1); ret_model++;
        exp_cyc(LD, 0, 1); exp_cyc(LD, 1, 1); exp_cyc(LD, 2, 1); exp_cyc(LD, 3, 1); exp_cyc(LD, 4, 1); ret_model++;
        exp_cyc(SD, 0, 1); exp_cyc(SD, 1, 1); exp_cyc(SD, 2, 1); exp_cyc(SD, 5, 1); ret_model++;
        exp_cyc(IT, 0, 1); exp_cyc(IT, 1, 1); exp_cyc(IT, 6, 1); exp_cyc(IT, 7, 1); ret_model++;
        exp_cyc(IT, 0, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk); opcode = r.op; mem_ready = r.rdy; #1;
            checks++;
            if (obs() !== r.v) begin
                failures++; $display("FAIL back_to_back cyc%0d got=%h want=%h", c, obs(), r.v);
            end
            c++;
        end
    endtask

    task automatic test_wrap();
        rec_t r;
        int c = 0;
        repeat (18) begin
            exp_cyc(BQ, 0, 1); exp_cyc(BQ, 1, 1); exp_cyc(BQ, 8, 1);
            ret_model++;
        end
        exp_cyc(BQ, 0, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk); opcode = r.op; mem_ready = r.rdy; #1;
            checks++;
            if (obs() !== r.v) begin
                failures++; $display("FAIL wrap cyc%0d got=%h want=%h", c, obs(), r.v);
            end
            c++;
        end
    endtask

    task automatic test_halt(input logic [6:0] op, input int hold);
        rec_t r;
        int c = 0;
        exp_cyc(op, 0, 1); exp_cyc(op, 1, 1);
        repeat (hold) exp_cyc(op, 9, 1'($urandom_range(0, 1)));
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk); opcode = r.op; mem_ready = r.rdy; #1;
            checks++;
            if (obs() !== r.v) begin
                failures++; $display("FAIL halt op=%b cyc%0d got=%h want=%h", op, c, obs(), r.v);
            end
            c++;
        end
        @(negedge clk); rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
        ret_model = '0;
        checks++;
        if (state !== 4'd0 || halted !== 1'b0 || retired !== '0) begin
            failures++; $display("FAIL halt_exit got state=%0d halted=%b retired=%0d want 0/0/0", state, halted, retired);
        end
    endtask

    task automatic test_rst_in_mem();
        rec_t r;
        int c = 0;
        exp_cyc(RT, 0, 1); exp_cyc(RT, 1, 1); exp_cyc(RT, 6, 1); exp_cyc(RT, 7, 1);
        ret_model++;
        exp_cyc(LD, 0, 1); exp_cyc(LD, 1, 1); exp_cyc(LD, 2, 1); exp_cyc(LD, 3, 0); exp_cyc(LD, 3, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk); opcode = r.op; mem_ready = r.rdy; #1;
            checks++;
            if (obs() !== r.v) begin
                failures++; $display("FAIL rst_mem_pre cyc%0d got=%h want=%h", c, obs(), r.v);
            end
            c++;
        end
        @(negedge clk); rst = 1'b1; mem_ready = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        ret_model = '0;
        checks++;
        if (state !== 4'd0 || retired !== '0 || {PCWrite, RegWrite, MemWrite} !== 3'b000) begin
            failures++; $display("FAIL rst_in_mem_read got state=%0d retired=%0d strobes=%b want 0/0/000",
                                 state, retired, {PCWrite, RegWrite, MemWrite});
        end
        exp_cyc(SD, 0, 1); exp_cyc(SD, 1, 1); exp_cyc(SD, 2, 1); exp_cyc(SD, 5, 0);
        c = 0;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk); opcode = r.op; mem_ready = r.rdy; #1;
            checks++;
            if (obs() !== r.v) begin
                failures++; $display("FAIL rst_mem_sd cyc%0d got=%h want=%h", c, obs(), r.v);
            end
            c++;
        end
        @(negedge clk); rst = 1'b1; mem_ready = 1'b0; #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            failures++; $display("FAIL rst_in_mem_write MemWrite got=%b want=0", MemWrite);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (state !== 4'd0 || retired !== '0) begin
            failures++; $display("FAIL rst_mem_write_exit got state=%0d retired=%0d want 0/0", state, retired);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype();
        test_load();
        test_store_stall();
        test_branch();
        test_fetch_stall();
        test_back_to_back();
        test_halt(7'b0000000, 20);
        test_halt(7'b1111111, 20);
        test_halt(7'b1010101, 3);
        test_wrap();
        test_rst_in_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
